// File: rtl/mesh_term_rx.sv
// Terminal-side receiver for one mesh router output port: pops packets from the
// router, tags them with a destination check and buffers them for a valid/ready consumer.
module mesh_term_rx #(
    parameter int PCKG_SZ    = 40,
    parameter int FIFO_DEPTH = 4,
    parameter int SELF_ROW   = 1,
    parameter int SELF_COL   = 1,
    parameter int CNT_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               pndng_i,
    input  logic [PCKG_SZ-1:0] data_out_i,
    output logic               pop_o,
    output logic               rx_valid_o,
    input  logic               rx_ready_i,
    output logic [7:0]         rx_nxt_jmp_o,
    output logic [3:0]         rx_row_o,
    output logic [3:0]         rx_col_o,
    output logic               rx_mode_o,
    output logic [PCKG_SZ-18:0] rx_payload_o,
    output logic               rx_dest_err_o,
    output logic [CNT_W-1:0]   pkt_count_o,
    output logic [CNT_W-1:0]   err_count_o
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

    state_t              state_q, state_d;
    logic                pop_q, pop_d;
    logic                wr_en, rd_en, dest_err_in;
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_FW-1:0]   fifo_cnt_q;
    logic [CNT_W-1:0]    pkt_count_q, err_count_q;
    logic [PCKG_SZ:0]    mem_q [FIFO_DEPTH];
    logic [PCKG_SZ:0]    head;

    // Room is judged only in IDLE; the count can only fall before the POP-cycle write.
    always_comb begin
        state_d = state_q;
        pop_d   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pndng_i && (fifo_cnt_q != CNT_FW'(FIFO_DEPTH))) begin
                    state_d = POP;
                    pop_d   = 1'b1;
                end
            end
            POP: begin
                wr_en   = 1'b1;
                state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rd_en       = rx_valid_o && rx_ready_i;
    assign dest_err_in = (data_out_i[PCKG_SZ-9 -: 4] != 4'(SELF_ROW)) ||
                         (data_out_i[PCKG_SZ-13 -: 4] != 4'(SELF_COL));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            pop_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q <= state_d;
            pop_q   <= pop_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_FW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_FW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
            if (wr_en && (pkt_count_q != '1)) begin
                pkt_count_q <= pkt_count_q + CNT_W'(1);
            end
            if (wr_en && dest_err_in && (err_count_q != '1)) begin
                err_count_q <= err_count_q + CNT_W'(1);
            end
        end
    end

    // Packet storage needs no reset; validity is tracked by the count alone.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {dest_err_in, data_out_i};
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign pop_o         = pop_q;
    assign rx_valid_o    = (fifo_cnt_q != '0);
    assign rx_nxt_jmp_o  = head[PCKG_SZ-1 -: 8];
    assign rx_row_o      = head[PCKG_SZ-9 -: 4];
    assign rx_col_o      = head[PCKG_SZ-13 -: 4];
    assign rx_mode_o     = head[PCKG_SZ-17];
    assign rx_payload_o  = head[PCKG_SZ-18:0];
    assign rx_dest_err_o = head[PCKG_SZ];
    assign pkt_count_o   = pkt_count_q;
    assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_mesh_term_rx.sv
// Bench for mesh_term_rx: a queue-based router model feeds packets, and a queue-based
// FIFO/counter model predicts every output sampled on the falling clock edge.
module tb_mesh_term_rx;

    localparam int PS = 40;
    localparam int FD = 4;
    localparam int SR = 1;
    localparam int SC = 2;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pndng;
    logic [PS-1:0] dataOut;
    logic          pop, rxValid, rxReady;
    logic [7:0]    rxNxtJmp;
    logic [3:0]    rxRow, rxCol;
    logic          rxMode, rxDestErr;
    logic [PS-18:0] rxPayload;
    logic [CW-1:0] pktCount, errCount;

    mesh_term_rx #(
        .PCKG_SZ(PS), .FIFO_DEPTH(FD), .SELF_ROW(SR), .SELF_COL(SC), .CNT_W(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .pndng_i(pndng), .data_out_i(dataOut),
        .pop_o(pop), .rx_valid_o(rxValid), .rx_ready_i(rxReady),
        .rx_nxt_jmp_o(rxNxtJmp), .rx_row_o(rxRow), .rx_col_o(rxCol),
        .rx_mode_o(rxMode), .rx_payload_o(rxPayload), .rx_dest_err_o(rxDestErr),
        .pkt_count_o(pktCount), .err_count_o(errCount)
    );

    always #5 clk = ~clk;

    logic [PS-1:0] routerQ[$];
    logic [PS-1:0] modelFifo[$];
    int            popCycles[$];
    int            evalCount = 0;
    int            failCount = 0;
    int            cycle = 0;
    int            modelPkt, modelErr, lastPopCycle, readySel;
    bit            lastPop, lastRead, prevPopSample;

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        evalCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit destErr(input logic [PS-1:0] p);
        return (p[PS-9 -: 4] != 4'(SR)) || (p[PS-13 -: 4] != 4'(SC));
    endfunction

    function automatic logic [PS-1:0] randPkt();
        return {8'($urandom), 4'($urandom_range(0, 2)), 4'($urandom_range(1, 3)),
                1'($urandom), 23'($urandom)};
    endfunction

    task automatic clearModel();
        modelFifo.delete();
        modelPkt      = 0;
        modelErr      = 0;
        lastPop       = 1'b0;
        lastRead      = 1'b0;
        prevPopSample = 1'b0;
        lastPopCycle  = -1;
    endtask

    task automatic checkOutput();
        logic [PS-1:0] p;
        checkEq("rxValid", 64'(rxValid), 64'(modelFifo.size() > 0));
        if (modelFifo.size() > 0) begin
            p = modelFifo[0];
            checkEq("rxNxtJmp", 64'(rxNxtJmp), 64'(p[PS-1 -: 8]));
            checkEq("rxRow", 64'(rxRow), 64'(p[PS-9 -: 4]));
            checkEq("rxCol", 64'(rxCol), 64'(p[PS-13 -: 4]));
            checkEq("rxMode", 64'(rxMode), 64'(p[PS-17]));
            checkEq("rxPayload", 64'(rxPayload), 64'(p[PS-18:0]));
            checkEq("rxDestErr", 64'(rxDestErr), 64'(destErr(p)));
        end
        checkEq("pktCount", 64'(pktCount), 64'(modelPkt));
        checkEq("errCount", 64'(errCount), 64'(modelErr));
        if (rst) checkEq("rstPop", 64'(pop), 64'(0));
        if (pop === 1'b1) begin
            checkEq("popWidth", 64'(prevPopSample), 64'(0));
            checkEq("popRoom", 64'(modelFifo.size() < FD), 64'(1));
            if (lastPopCycle >= 0) checkEq("popSpacing", 64'((cycle - lastPopCycle) >= 3), 64'(1));
            lastPopCycle = cycle;
            popCycles.push_back(cycle);
        end
        prevPopSample = (pop === 1'b1);
    endtask

    // One clock: retire what the previous edge did, check, then drive the next edge.
    task automatic applyStimulus();
        logic [PS-1:0] p;
        @(negedge clk);
        cycle++;
        if (!rst) begin
            if (lastPop && routerQ.size() > 0) begin
                p = routerQ.pop_front();
                modelFifo.push_back(p);
                if (modelPkt < CNT_MAX) modelPkt++;
                if (destErr(p) && modelErr < CNT_MAX) modelErr++;
            end
            if (lastRead && modelFifo.size() > 0) void'(modelFifo.pop_front());
        end
        checkOutput();
        pndng   = (routerQ.size() > 0);
        dataOut = (routerQ.size() > 0) ? routerQ[0] : '0;
        rxReady = (readySel == 2) ? 1'($urandom_range(0, 1)) : (readySel == 1);
        lastPop  = (pop === 1'b1) && !rst;
        lastRead = (rxValid === 1'b1) && rxReady && !rst;
    endtask

    task automatic checkPopSpacing(input string tag, input int expectedPops);
        checkEq({tag, "Pops"}, 64'(popCycles.size()), 64'(expectedPops));
        for (int i = 1; i < popCycles.size(); i++)
            checkEq({tag, "Gap"}, 64'(popCycles[i] - popCycles[i-1]), 64'(3));
    endtask

    task automatic doReset(input int n);
        rst = 1'b1;
        clearModel();
        repeat (n) applyStimulus();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pndng = 1'b0; dataOut = '0; rxReady = 1'b0; readySel = 1;
        clearModel();

        $display("[TB] test 1: reset held with pndng high");
        routerQ.push_back(randPkt());
        doReset(5);
        routerQ.delete();
        pndng = 1'b0;

        $display("[TB] test 2: matching destination");
        routerQ.push_back(40'h00_1_2_012345);
        popCycles.delete();
        for (int i = 0; i < 10 && rxValid !== 1'b1; i++) applyStimulus();
        checkEq("t2Valid", 64'(rxValid), 64'(1));
        checkEq("t2Row", 64'(rxRow), 64'(1));
        checkEq("t2Col", 64'(rxCol), 64'(2));
        checkEq("t2Mode", 64'(rxMode), 64'(0));
        checkEq("t2Payload", 64'(rxPayload), 64'(23'h012345));
        checkEq("t2DestErr", 64'(rxDestErr), 64'(0));
        checkEq("t2PktCount", 64'(pktCount), 64'(1));
        repeat (4) applyStimulus();
        checkPopSpacing("t2", 1);

        $display("[TB] test 3: wrong row, mode set");
        routerQ.push_back(40'h00_3_2_812345);
        for (int i = 0; i < 10 && rxValid !== 1'b1; i++) applyStimulus();
        checkEq("t3Valid", 64'(rxValid), 64'(1));
        checkEq("t3Row", 64'(rxRow), 64'(3));
        checkEq("t3Mode", 64'(rxMode), 64'(1));
        checkEq("t3Payload", 64'(rxPayload), 64'(23'h012345));
        checkEq("t3DestErr", 64'(rxDestErr), 64'(1));
        checkEq("t3ErrCount", 64'(errCount), 64'(1));
        repeat (4) applyStimulus();

        $display("[TB] test 4: consumer stalled until FIFO full");
        readySel = 0;
        repeat (6) routerQ.push_back(randPkt());
        popCycles.delete();
        repeat (30) applyStimulus();
        checkPopSpacing("t4Full", 4);
        readySel = 1;
        applyStimulus();
        readySel = 0;
        popCycles.delete();
        repeat (15) applyStimulus();
        checkEq("t4OneMorePops", 64'(popCycles.size()), 64'(1));
        readySel = 1;
        repeat (25) applyStimulus();
        checkEq("t4Drained", 64'(routerQ.size() + modelFifo.size()), 64'(0));

        $display("[TB] test 5: back-to-back packets");
        doReset(2);
        readySel = 1;
        repeat (8) routerQ.push_back(randPkt());
        popCycles.delete();
        for (int i = 0; i < 60 && (routerQ.size() > 0 || modelFifo.size() > 0); i++) applyStimulus();
        repeat (3) applyStimulus();
        checkPopSpacing("t5", 8);
        checkEq("t5PktCount", 64'(pktCount), 64'(8));

        $display("[TB] test 6: reset while pop is high");
        readySel = 0;
        repeat (3) routerQ.push_back(randPkt());
        for (int i = 0; i < 10 && pop !== 1'b1; i++) applyStimulus();
        checkEq("t6PopSeen", 64'(pop), 64'(1));
        rst = 1'b1;
        clearModel();
        #1;
        checkEq("t6PopDrop", 64'(pop), 64'(0));
        checkEq("t6Empty", 64'(rxValid), 64'(0));
        checkEq("t6PktCount", 64'(pktCount), 64'(0));
        repeat (2) applyStimulus();
        rst = 1'b0;
        readySel = 1;
        repeat (20) applyStimulus();
        checkEq("t6Resumed", 64'(pktCount), 64'(3));

        $display("[TB] random traffic with saturating counters");
        readySel = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0 && routerQ.size() < 6) routerQ.push_back(randPkt());
            applyStimulus();
        end
        readySel = 1;
        for (int i = 0; i < 200 && (routerQ.size() > 0 || modelFifo.size() > 0); i++) applyStimulus();
        repeat (3) applyStimulus();
        checkEq("rndDrained", 64'(routerQ.size() + modelFifo.size()), 64'(0));
        checkEq("rndPktSat", 64'(pktCount), 64'(CNT_MAX));

        $display("End of test - %0d assertions evaluated, %0d failures", evalCount, failCount);
        $finish;
    end

endmodule
